// File: rtl/hyperbus_pkg.sv
// -----------------------------------------------------------------------------
// hyperbus_pkg
// Shared types and constants for the HyperBus controller request path.
//   NumChipsMax        : widest chip-select vector carried by the sub-burst type
//   LenWidth           : width of word-count fields
//   hyperbus_sub_req_t : one chip-local sub-burst (chip, offset, len, write, last)
//   split_state_e      : chip splitter FSM states
//   min_u32            : unsigned 32-bit minimum helper
// -----------------------------------------------------------------------------
package hyperbus_pkg;

  localparam int unsigned NumChipsMax = 2;
  localparam int unsigned LenWidth    = 16;

  typedef struct packed {
    logic [NumChipsMax-1:0] chip;
    logic [31:0]            offset;
    logic [LenWidth-1:0]    len;
    logic                   write;
    logic                   last;
  } hyperbus_sub_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ISSUE
  } split_state_e;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/hyperbus_chip_splitter_if.sv
// -----------------------------------------------------------------------------
// hyperbus_chip_splitter_if
// Request and sub-burst channels of the chip splitter.
//   req_* : linear word-burst request (valid/ready)
//   sub_* : chip-local sub-burst (valid/ready)
// Modports:
//   slave  : the splitter (consumes requests, produces sub-bursts)
//   master : the surrounding logic (produces requests, consumes sub-bursts)
// -----------------------------------------------------------------------------
interface hyperbus_chip_splitter_if #(
  parameter int unsigned NumChips = 2,
  parameter int unsigned LenWidth = 16
);

  logic                req_valid_i;
  logic                req_ready_o;
  logic [31:0]         req_addr_i;
  logic [LenWidth-1:0] req_len_i;
  logic                req_write_i;

  logic                sub_valid_o;
  logic                sub_ready_i;
  logic [NumChips-1:0] sub_chip_o;
  logic [31:0]         sub_offset_o;
  logic [LenWidth-1:0] sub_len_o;
  logic                sub_write_o;
  logic                sub_last_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_len_i, req_write_i, sub_ready_i,
    output req_ready_o, sub_valid_o, sub_chip_o, sub_offset_o, sub_len_o,
           sub_write_o, sub_last_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_len_i, req_write_i, sub_ready_i,
    input  req_ready_o, sub_valid_o, sub_chip_o, sub_offset_o, sub_len_o,
           sub_write_o, sub_last_o
  );

endinterface

// File: rtl/hyperbus_chip_decode.sv
// -----------------------------------------------------------------------------
// hyperbus_chip_decode
// Combinational address-to-chip decoder.
//   i_addr   : byte address to decode
//   i_ranges : per-chip [0] start (inclusive) / [1] end (exclusive)
//   o_match  : one-hot selected chip (lowest matching index)
//   o_valid  : some range matched
//   o_start  : start of the selected range
//   o_end    : end of the selected range
// -----------------------------------------------------------------------------
module hyperbus_chip_decode #(
  parameter int unsigned NumChips = 2
) (
  input  logic [31:0]                      i_addr,
  input  logic [NumChips-1:0][1:0][31:0]   i_ranges,
  output logic [NumChips-1:0]              o_match,
  output logic                             o_valid,
  output logic [31:0]                      o_start,
  output logic [31:0]                      o_end
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    o_match = '0;
    o_valid = 1'b0;
    o_start = '0;
    o_end   = '0;
    // Scan from the top down so the lowest matching index overwrites last.
    // An empty or inverted range (end <= start) can never satisfy both compares.
    for (int i = NumChips - 1; i >= 0; i--) begin
      if ((i_addr >= i_ranges[i][0]) && (i_addr < i_ranges[i][1])) begin
        o_match    = '0;
        o_match[i] = 1'b1;
        o_valid    = 1'b1;
        o_start    = i_ranges[i][0];
        o_end      = i_ranges[i][1];
      end
    end
  end

endmodule

// File: rtl/hyperbus_chip_splitter.sv
// -----------------------------------------------------------------------------
// hyperbus_chip_splitter
// Splits linear word-burst requests into sub-bursts that stay inside one chip
// range and never exceed MaxBurstWords words.
//   clk_i             : clock
//   rst_i             : synchronous active-high reset
//   chip_addr_range_i : per-chip [start, end) byte ranges, sampled live
//   bus               : request / sub-burst channels (slave side)
//   err_o             : one-cycle pulse on unmapped address or zero length
// -----------------------------------------------------------------------------
module hyperbus_chip_splitter
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumChips      = 2,
  parameter int unsigned MaxBurstWords = 256,
  parameter int unsigned LenWidth      = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumChips-1:0][1:0][31:0] chip_addr_range_i,
  hyperbus_chip_splitter_if.slave        bus,
  output logic                           err_o
);

  split_state_e        r_state;
  split_state_e        w_next_state;
  logic [31:0]         r_cur_addr;
  logic [LenWidth-1:0] r_remaining;
  logic                r_write;
  hyperbus_sub_req_t   r_sub;
  logic                r_err;

  logic [NumChips-1:0] w_match;
  logic                w_hit;
  logic [31:0]         w_start;
  logic [31:0]         w_end;
  logic [31:0]         w_room;
  logic [31:0]         w_chunk;
  logic                w_dec_err;
  logic                w_req_fire;
  logic                w_sub_fire;

  hyperbus_chip_decode #(.NumChips(NumChips)) u_decode (
    .i_addr   (r_cur_addr),
    .i_ranges (chip_addr_range_i),
    .o_match  (w_match),
    .o_valid  (w_hit),
    .o_start  (w_start),
    .o_end    (w_end)
  );

  assign w_req_fire = bus.req_valid_i & bus.req_ready_o;
  assign w_sub_fire = bus.sub_valid_o & bus.sub_ready_i;

  // Words left before the range end; only meaningful on a hit, where end > cur_addr.
  always_comb begin
    w_room    = (w_end - r_cur_addr) >> 1;
    w_chunk   = min_u32(min_u32(32'(r_remaining), 32'(MaxBurstWords)), w_room);
    // A zero chunk also covers an odd end one byte past cur_addr: nothing fits.
    w_dec_err = !w_hit || (r_remaining == '0) || (w_chunk == '0);
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_req_fire) w_next_state = ST_DECODE;
      ST_DECODE: w_next_state = w_dec_err ? ST_IDLE : ST_ISSUE;
      ST_ISSUE:  if (w_sub_fire) w_next_state = r_sub.last ? ST_IDLE : ST_DECODE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Request bookkeeping and the registered sub-burst.
  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: every register here is reset; the sub_* outputs must read zero out of reset.
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_write     <= 1'b0;
      r_sub       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            r_cur_addr  <= bus.req_addr_i & ~32'd1;
            r_remaining <= bus.req_len_i;
            r_write     <= bus.req_write_i;
          end
        end
        ST_DECODE: begin
          if (w_dec_err) begin
            r_err <= 1'b1;
          end else begin
            r_sub.chip   <= NumChipsMax'(w_match);
            r_sub.offset <= r_cur_addr - w_start;
            r_sub.len    <= hyperbus_pkg::LenWidth'(w_chunk);
            r_sub.write  <= r_write;
            r_sub.last   <= (w_chunk == 32'(r_remaining));
          end
        end
        ST_ISSUE: begin
          if (w_sub_fire) begin
            r_remaining <= r_remaining - LenWidth'(r_sub.len);
            r_cur_addr  <= r_cur_addr + (32'(r_sub.len) << 1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs. Ready stays low during the error pulse so a new request is
  // accepted only after the error has been seen downstream.
  always_comb begin
    bus.req_ready_o = (r_state == ST_IDLE) & ~rst_i & ~r_err;
    bus.sub_valid_o = (r_state == ST_ISSUE);
    err_o           = r_err;
  end

  assign bus.sub_chip_o   = NumChips'(r_sub.chip);
  assign bus.sub_offset_o = r_sub.offset;
  assign bus.sub_len_o    = LenWidth'(r_sub.len);
  assign bus.sub_write_o  = r_sub.write;
  assign bus.sub_last_o   = r_sub.last;

endmodule
